// File: rtl/uart_pkg.sv
// Shared UART constants and types for the 8N1 link at 50 MHz / 19200 baud.
package uart_pkg;

  typedef enum logic {IDLE, RECV} rx_state_t;

  localparam int BAUD_CLKS  = 2604;
  localparam int HALF_CLKS  = BAUD_CLKS / 2;
  localparam int FRAME_BITS = 10;
  localparam int CNT_W      = 12;
  localparam int BIT_W      = 4;

endpackage

// File: rtl/rx_sync.sv
// Two-flop RX synchronizer, preset high, plus an edge flop for start-bit detection.
// Latency 2 clk to rx_s; fall pulses for one cycle on a synchronized 1-to-0 transition.
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic s1;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= rx;
      rx_s <= s1;
      prev <= rx_s;
    end
  end

  assign fall = prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, rdy/clr_rdy handshake, framing and overrun flags.
// rdy rises HALF + 9*BAUD + 1 clk after edge detect; the consumer never stalls reception (overrun instead).
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD = BAUD_CLKS,
  parameter int HALF = BAUD / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr
);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF);
  // Strobe fires on the count of zero, so BAUD-1 gives a period of exactly BAUD clks.
  localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(BAUD - 1);
  localparam logic [BIT_W-1:0] STOP_IDX  = BIT_W'(FRAME_BITS - 1);

  logic             rx_s;
  logic             fall;
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [7:0]       shreg;
  logic             strobe;
  logic             done;

  rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (RX),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    strobe    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_nxt = RECV;
      end
      RECV: begin
        if (baud_cnt == '0) begin
          strobe = 1'b1;
          // A start bit that reads high at mid-bit was a glitch.
          if (bit_cnt == '0 && rx_s) begin
            state_nxt = IDLE;
          end else if (bit_cnt == STOP_IDX) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (state == IDLE) begin
      if (fall) begin
        baud_cnt <= HALF_LOAD;
        bit_cnt  <= '0;
      end
    end else if (strobe) begin
      baud_cnt <= BAUD_LOAD;
      bit_cnt  <= bit_cnt + BIT_W'(1);
      if (bit_cnt != '0 && bit_cnt != STOP_IDX) shreg <= {rx_s, shreg[7:1]};
    end else begin
      baud_cnt <= baud_cnt - CNT_W'(1);
    end
  end

  // Completion beats a same-cycle clr_rdy; the cleared byte counts as consumed so ovr drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr     <= 1'b0;
    end else if (done) begin
      rx_data <= shreg;
      frm_err <= ~rx_s;
      rdy     <= 1'b1;
      ovr     <= clr_rdy ? 1'b0 : (ovr | rdy);
    end else if (clr_rdy) begin
      rdy <= 1'b0;
      ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a shortened bit period; frames driven bit-by-bit on RX.
module tb_uart_rx;

  localparam int BAUD = 64;
  localparam int HALF = 32;
  // Clock edges from the RX fall (driven just after an edge) until rdy is visible.
  localparam int LAT  = HALF + 9 * BAUD + 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       clr;
    logic [7:0] e_data;
    logic       e_rdy;
    logic       e_frm;
    logic       e_ovr;
  } vec_t;

  vec_t vt[9];

  uart_rx #(.BAUD(BAUD), .HALF(HALF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr     (ovr)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      tick(BAUD);
    end
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int   lat;
    logic rdy0;
    rdy0 = rdy;
    lat  = 0;
    fork
      send_frame(vt[i].d, vt[i].stop);
      begin
        if (vt[i].clr) begin
          tick(BAUD);
          pulse_clr();
        end
      end
      begin
        if (!rdy0) begin
          while (!rdy && lat < LAT + 50) begin
            tick(1);
            lat++;
          end
          checks++;
          if (lat < LAT - 1 || lat > LAT + 1) begin
            errors++;
            $display("FAIL latency vec%0d actual=%0d expected=%0d", i, lat, LAT);
          end
        end
      end
    join
    chk($sformatf("rx_data vec%0d", i), 32'(rx_data), 32'(vt[i].e_data));
    chk($sformatf("rdy vec%0d", i),     32'(rdy),     32'(vt[i].e_rdy));
    chk($sformatf("frm_err vec%0d", i), 32'(frm_err), 32'(vt[i].e_frm));
    chk($sformatf("ovr vec%0d", i),     32'(ovr),     32'(vt[i].e_ovr));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    RX      = 1'b1;
    clr_rdy = 1'b0;
    //          data   stop  clr   e_data e_rdy e_frm e_ovr
    vt[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vt[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[3] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0};
    vt[4] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vt[5] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};
    vt[6] = '{8'h30, 1'b1, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0};
    vt[7] = '{8'h33, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1};
    vt[8] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};

    #35;
    chk("reset rx_data", 32'(rx_data), 32'h00);
    chk("reset rdy",     32'(rdy),     32'h0);
    chk("reset frm_err", 32'(frm_err), 32'h0);
    chk("reset ovr",     32'(ovr),     32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(4);

    for (int i = 0; i < 9; i++) begin
      run_vec(i);
      if (i == 1) begin
        // Short low pulse: the mid-start sample sees high again.
        pulse_clr();
        RX = 1'b0;
        tick(HALF / 2);
        RX = 1'b1;
        tick(2 * BAUD);
        chk("glitch rdy",     32'(rdy),     32'h0);
        chk("glitch rx_data", 32'(rx_data), 32'h3C);
      end
      if (i == 3) begin
        // RX stays low after the bad stop bit; no new frame without a falling edge.
        pulse_clr();
        tick(3 * BAUD);
        chk("held low rdy", 32'(rdy), 32'h0);
        RX = 1'b1;
        tick(BAUD);
        chk("held low rdy after release", 32'(rdy), 32'h0);
      end
      if (i == 5) begin
        pulse_clr();
        chk("clear rdy",     32'(rdy),     32'h0);
        chk("clear ovr",     32'(ovr),     32'h0);
        chk("clear rx_data", 32'(rx_data), 32'h22);
      end
      if (i == 7) begin
        fork
          send_frame(8'h44, 1'b1);
          begin
            tick(LAT - 1);
            clr_rdy = 1'b1;
            tick(1);
            clr_rdy = 1'b0;
          end
        join
        chk("simul rx_data", 32'(rx_data), 32'h44);
        chk("simul rdy",     32'(rdy),     32'h1);
        chk("simul ovr",     32'(ovr),     32'h0);

        fork
          send_frame(8'hFF, 1'b1);
          begin
            tick(5 * BAUD + BAUD / 2);
            rst_n = 1'b0;
            #1;
            chk("midreset rx_data", 32'(rx_data), 32'h00);
            chk("midreset rdy",     32'(rdy),     32'h0);
            chk("midreset frm_err", 32'(frm_err), 32'h0);
            chk("midreset ovr",     32'(ovr),     32'h0);
            tick(3);
            rst_n = 1'b1;
          end
        join
        tick(BAUD);
        chk("midreset no rdy", 32'(rdy), 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
